// File: rtl/register_file_c.sv
// Sixteen-entry register file with R15 as program counter (auto-increment path).
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_WR_BYPASS_EN.
module register_file_c #(
  parameter int                DATA_W   = 32,
  parameter int                PC_STEP  = 4,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              pc_inc,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] pc_out
);

  localparam logic [3:0]        PC_IDX  = 4'd15;
  localparam logic [DATA_W-1:0] PC_INCR = DATA_W'(PC_STEP);

  logic [DATA_W-1:0] regs [16];
  logic              wr_pc;
  logic              inc_pc;

  assign wr_pc  = wr_en && (wr_addr == PC_IDX);
  // A write to R15 is a branch/link and overrides sequential flow.
  assign inc_pc = pc_inc && !wr_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= '0;
      end
      regs[15] <= PC_RESET;
    end else begin
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
      end
      if (inc_pc) begin
        regs[15] <= regs[15] + PC_INCR;
      end
    end
  end

`ifdef REGFILE_WR_BYPASS_EN
  // Only the write port is forwarded; a pending increment is not.
  assign rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : regs[rd_addr_a];
  assign rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : regs[rd_addr_b];
`else
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
`endif

  assign pc_out = regs[15];

endmodule

// File: tb/tb_register_file_c.sv
// Directed self-checking bench for register_file_c (default parameters).
module tb_register_file_c;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        pc_inc;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;

  register_file_c dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .pc_inc    (pc_inc),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    pc_inc = 1'b0;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic read_a(input logic [3:0] a, output logic [31:0] d);
    rd_addr_a = a;
    #1;
    d = rd_data_a;
  endtask

  logic [31:0] v;
  logic [31:0] bypass_exp;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; pc_inc = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    #2;

    // Reset with a write and increment pending: both must be discarded.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF; pc_inc = 1'b1;
    tick();
    tick();
    idle();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      #1;
      check($sformatf("reset_a_r%0d", i), rd_data_a, 32'h0);
      check($sformatf("reset_b_r%0d", 15 - i), rd_data_b, 32'h0);
    end
    check("reset_pc", pc_out, 32'h0);

    // Basic write/read on both ports, neighbours untouched.
    write(4'd5, 32'h1234_5678);
    rd_addr_a = 4'd5; rd_addr_b = 4'd5; #1;
    check("r5_port_a", rd_data_a, 32'h1234_5678);
    check("r5_port_b", rd_data_b, 32'h1234_5678);
    read_a(4'd4, v); check("r4_untouched", v, 32'h0);
    read_a(4'd6, v); check("r6_untouched", v, 32'h0);

    // R0 is an ordinary register.
    write(4'd0, 32'hA5A5_0F0F);
    read_a(4'd0, v); check("r0_writable", v, 32'hA5A5_0F0F);

    // Plain increments from reset value.
    pc_inc = 1'b1; tick(); pc_inc = 1'b0;
    check("pc_inc_1", pc_out, 32'h4);
    pc_inc = 1'b1; tick(); tick(); pc_inc = 1'b0;
    check("pc_inc_3", pc_out, 32'hC);

    // PC wrap.
    write(4'd15, 32'hFFFF_FFFC);
    check("pc_pre_wrap", pc_out, 32'hFFFF_FFFC);
    pc_inc = 1'b1; tick(); pc_inc = 1'b0;
    check("pc_wrap", pc_out, 32'h0);

    // Collision on R15: write wins, then increment resumes.
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h0000_0100; pc_inc = 1'b1;
    tick();
    wr_en = 1'b0;
    check("pc_collision", pc_out, 32'h100);
    tick(); pc_inc = 1'b0;
    check("pc_after_collision", pc_out, 32'h104);

    // Independent write alongside increment.
    write(4'd15, 32'h20);
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'h24; pc_inc = 1'b1;
    tick();
    idle();
    read_a(4'd14, v); check("r14_link", v, 32'h24);
    check("pc_with_link", pc_out, 32'h24);
    read_a(4'd15, v); check("r15_port_a", v, 32'h24);

    // Same-cycle read of the write address.
    write(4'd7, 32'h11);
`ifdef REGFILE_WR_BYPASS_EN
    bypass_exp = 32'h22;
`else
    bypass_exp = 32'h11;
`endif
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h22;
    rd_addr_a = 4'd7; rd_addr_b = 4'd7; #1;
    check("bypass_pre_a", rd_data_a, bypass_exp);
    check("bypass_pre_b", rd_data_b, bypass_exp);
    tick();
    wr_en = 1'b0; #1;
    check("bypass_post_a", rd_data_a, 32'h22);
    check("bypass_post_b", rd_data_b, 32'h22);

    // Increment is never forwarded to a read of R15.
    pc_inc = 1'b1; rd_addr_a = 4'd15; #1;
    check("pc_inc_not_bypassed", rd_data_a, 32'h24);
    tick(); pc_inc = 1'b0; #1;
    check("pc_inc_visible", rd_data_a, 32'h28);

    // Mid-operation reset clears everything and discards pending updates.
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hCAFE_F00D; pc_inc = 1'b1;
    tick();
    idle();
    rst_n = 1'b1;
    read_a(4'd5, v); check("rst_mid_r5", v, 32'h0);
    read_a(4'd14, v); check("rst_mid_r14", v, 32'h0);
    check("rst_mid_pc", pc_out, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_c.md
# register_file_c

Sixteen-entry general-purpose register file for the basic RISC data path. It sits directly downstream of the destination-address multiplexer. Its write port takes the 4-bit destination address that the multiplexer produces: Rd, R14 or R15 for link writes. It also provides two combinational read ports to the ALU operand path. R15 doubles as the program counter and has a dedicated auto-increment path, so the control unit can advance the PC without using the write port.

## Interface
- DATA_W, 32, register width in bits
- PC_STEP, 4, amount added to R15 on each pc_inc
- PC_RESET, 0, value loaded into R15 at reset

- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- wr_addr  input  4  write address (destination-address mux output)
- wr_data  input  DATA_W  write data
- wr_en  input  1  write enable
- pc_inc  input  1  add PC_STEP to R15 this cycle
- rd_addr_a  input  4  read port A address
- rd_addr_b  input  4  read port B address
- rd_data_a  output  DATA_W  read port A data
- rd_data_b  output  DATA_W  read port B data
- pc_out  output  DATA_W  current R15 value, always visible

## Operation
- Storage: R0–R15, each DATA_W bits. All sixteen registers are writable; R0 is not hardwired.
- Reads are combinational: rd_data_x = R[rd_addr_x], with no clock involvement.
- Write: on a rising edge with rst_n=1 and wr_en=1, R[wr_addr] ← wr_data.
- PC increment: on a rising edge with rst_n=1 and pc_inc=1, R15 ← R15 + PC_STEP.
  - The sum is taken modulo 2^DATA_W, so 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
  - No carry or overflow flag is produced.
- Write and increment in the same cycle:
  - wr_en=1, wr_addr=15 and pc_inc=1: the write wins and R15 ← wr_data. The increment is dropped, because a branch or link overrides sequential flow.
  - wr_en=1 to any other address with pc_inc=1: both updates happen.
- Reset: while rst_n=0 at a rising edge, R0–R14 ← 0 and R15 ← PC_RESET. Reset overrides wr_en and pc_inc.
- Reset mid-operation: any write or increment presented on a reset edge is discarded.
- Reset value of outputs: rd_data_a and rd_data_b show 0 for any address other than 15 (PC_RESET for address 15). pc_out = PC_RESET.
- Both read ports may address the same register, including the write address, with no conflict.

## Timing
- Write latency is one cycle: data written at edge N is visible on the read ports after edge N. With bypass enabled it is also visible in the same cycle, before edge N.
- Increment latency is one cycle: pc_out changes immediately after the edge that samples pc_inc=1.
- Inputs are sampled only at the rising edge of clk. Outputs are combinational from register state, and from write inputs when bypass is enabled.
- No handshake: the block is always ready, and a write completes every cycle that wr_en=1.

## Configuration
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: a read port whose address equals wr_addr while wr_en=1 returns wr_data combinationally in that same cycle. This removes the write-back-to-read hazard.
  - A read of address 15 with pc_inc=1 and no write to 15 still returns the stored R15. The increment is not bypassed.
- Undefined: read ports return stored register contents only. Same-cycle reads of the write address return the old value.

## Test plan
- Reset and default state:
  - Hold rst_n=0 for 2 cycles with PC_RESET=0, then read all 16 addresses → every register reads 0 and pc_out=0.
  - In the same reset cycle, drive wr_en=1, wr_addr=3, wr_data=0xDEAD_BEEF, then release reset → R3 reads 0.
- Basic write/read: write 0x1234_5678 to R5, then read R5 on port A and port B at the same time → both return 0x1234_5678 after the edge.
- PC wrap: write 0xFFFF_FFFC to R15, then pulse pc_inc for one cycle → pc_out=0x0000_0000.
- Collision on R15: wr_en=1, wr_addr=15, wr_data=0x0000_0100 with pc_inc=1 → R15=0x100, not 0x104.
  - Next cycle pc_inc=1 alone → R15=0x104.
- Independent write with increment: R15=0x20, then wr_en=1, wr_addr=14, wr_data=0x24 with pc_inc=1 → R14=0x24 and R15=0x24.
- Bypass, both builds: set R7=0x11, then in one cycle drive wr_en=1, wr_addr=7, wr_data=0x22 and rd_addr_a=7.
  - Before the edge, rd_data_a=0x22 with REGFILE_WR_BYPASS_EN defined, and 0x11 without it.
  - After the edge, both builds read 0x22.
